hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller. It stalls the front end on load-use
// hazards, flushes IF/ID and bubbles ID/EX for FLUSH_CYCLES cycles per control
// redirect, and freezes everything while data memory is waiting.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   input  logic        ex_redirect,
   input  logic        ext_stall,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        id_ex_hold,
   output logic        flushing,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   localparam logic ST_RUN   = 1'b0;
   localparam logic ST_FLUSH = 1'b1;

   // Bubble cycles still owed after the redirect cycle itself.
   localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
   localparam logic       MULTI_CYCLE  = (FLUSH_CYCLES > 1);

   logic       state;
   logic [1:0] flush_left;
   logic       load_use;

   // A load in EX whose destination (never r0) is read by the instruction in ID.
   assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rt)) ||
                      (id_uses_rt && (id_rt == ex_rt)));

   // The registered FSM state doubles as the visible flush indicator.
   assign flushing = (state == ST_FLUSH);

   // Control outputs, highest priority first: reset, memory wait, redirect,
   // ongoing flush, load-use stall, normal flow.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      id_ex_hold   = 1'b0;
      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (ext_stall) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_hold  = 1'b1;
      end else if (ex_redirect || (state == ST_FLUSH)) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (load_use) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   // State, flush down-counter and saturating event counters, same priority
   // order as the outputs; a memory wait freezes all of it, so a redirect
   // presented during the wait is taken only once the wait ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         flush_left  <= 2'd0;
         stall_count <= 16'd0;
         flush_count <= 16'd0;
      end else if (ext_stall) begin
         state <= state;
      end else if (ex_redirect) begin
         if (flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
         if (MULTI_CYCLE) begin
            state      <= ST_FLUSH;
            flush_left <= FLUSH_RELOAD;
         end else begin
            state      <= ST_RUN;
            flush_left <= 2'd0;
         end
      end else if (state == ST_FLUSH) begin
         if (flush_left <= 2'd1) begin
            state      <= ST_RUN;
            flush_left <= 2'd0;
         end else begin
            flush_left <= flush_left - 2'd1;
         end
      end else if (load_use) begin
         if (stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      end
   end

endmodule
